// File: rtl/struct_stream_pkg.sv
// Shared beat layout, checker state encoding and default LFSR constants
// for the struct-packed {mode, data} stream.
package struct_stream_pkg;

    localparam int unsigned BEAT_DATA_W = 8;
    localparam int unsigned BEAT_MODE_W = 2;

    localparam logic [BEAT_DATA_W-1:0] DEFAULT_TAPS = 8'hB8;
    localparam logic [BEAT_DATA_W-1:0] DEFAULT_SEED = 8'h01;

    typedef struct packed {
        logic [BEAT_MODE_W-1:0] mode;
        logic [BEAT_DATA_W-1:0] data;
    } beat_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        PASS  = 2'd2,
        FAIL  = 2'd3
    } state_t;

endpackage

// File: rtl/struct_stream_checker_lfsr.sv
// Galois LFSR holding the expected data value; advance takes priority over
// load, and reset/load both return it to SEED.
module galois_lfsr #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             advance,
    input  logic             load,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (advance) begin
            value_d = (value_q >> 1) ^ (value_q[0] ? TAPS : '0);
        end else if (load) begin
            value_d = SEED;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            value_q <= SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/struct_stream_checker.sv
// Receiving-end checker: aligns on the first mode-0 beat, then compares each
// accepted beat against an LFSR data model and an incrementing mode counter.
module struct_stream_checker
    import struct_stream_pkg::*;
#(
    parameter int unsigned        DATA_W     = 8,
    parameter int unsigned        MODE_W     = 2,
    parameter logic [DATA_W-1:0]  TAPS       = DEFAULT_TAPS,
    parameter logic [DATA_W-1:0]  SEED       = DEFAULT_SEED,
    parameter int unsigned        PASS_COUNT = 16,
    parameter int unsigned        CNT_W      = 8
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [MODE_W-1:0] in_mode,
    output logic              success,
    output logic              error,
    output logic [CNT_W-1:0]  match_count,
    output logic              busy
);

    localparam logic [CNT_W:0] PASS_CNT = (CNT_W+1)'(PASS_COUNT);

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [MODE_W-1:0]  exp_mode_q, exp_mode_d;
    logic [DATA_W-1:0]  exp_data;
    logic               model_adv;
    logic               accept;
    logic               beat_match;
    logic [CNT_W:0]     count_inc;
    logic [CNT_W-1:0]   count_sat;

    assign accept     = in_valid && in_ready_q;
    assign beat_match = (in_data == exp_data) && (in_mode == exp_mode_q);
    // Unsaturated increment decides PASS; the stored count saturates separately.
    assign count_inc  = {1'b0, count_q} + (CNT_W+1)'(1);
    assign count_sat  = (count_q == '1) ? count_q : count_inc[CNT_W-1:0];

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        exp_mode_d = exp_mode_q;
        model_adv  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept && (in_mode == '0)) begin
                    if (in_data == SEED) begin
                        model_adv = 1'b1;
                        count_d   = CNT_W'(1);
                        state_d   = (PASS_CNT == (CNT_W+1)'(1)) ? PASS : CHECK;
                    end else begin
                        state_d = FAIL;
                    end
                end
            end
            CHECK, PASS: begin
                if (accept) begin
                    if (beat_match) begin
                        model_adv = 1'b1;
                        count_d   = count_sat;
                        if ((state_q == CHECK) && (count_inc == PASS_CNT)) begin
                            state_d = PASS;
                        end
                    end else begin
                        state_d = FAIL;
                    end
                end
            end
            default: begin
                state_d = FAIL;
            end
        endcase

        if (model_adv) begin
            exp_mode_d = exp_mode_q + MODE_W'(1);
        end
        in_ready_d = (state_d != FAIL);
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            count_q    <= '0;
            exp_mode_q <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            count_q    <= count_d;
            exp_mode_q <= exp_mode_d;
        end
    end

    galois_lfsr #(
        .WIDTH (DATA_W),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_exp_data (
        .clock   (clock),
        .clear_n (clear_n),
        .advance (model_adv),
        .load    ((state_q == IDLE) && !model_adv),
        .value   (exp_data)
    );

    assign in_ready    = in_ready_q;
    assign match_count = count_q;
    assign busy        = (state_q == CHECK) || (state_q == PASS);
    assign success     = (state_q == PASS);
    assign error       = (state_q == FAIL);

endmodule
